// File: rtl/pipeline_hazard_scoreboard_if.sv
// Pipeline latch / mult-div bundle between the datapath (master) and the
// hazard scoreboard (slave).
interface pipeline_hazard_scoreboard_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fd_instr;
    logic [XLEN-1:0] dx_instr;
    logic [XLEN-1:0] xm_instr;
    logic [XLEN-1:0] mw_instr;
    logic            xm_err;
    logic            mw_err;
    logic            md_rdy;
    logic            md_exc;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic            stall;
    logic            md_start;
    logic            md_busy;
    logic            md_timeout;
    logic            md_err;

    modport master (
        output fd_instr, dx_instr, xm_instr, mw_instr, xm_err, mw_err, md_rdy, md_exc,
        input  a_sel, b_sel, stall, md_start, md_busy, md_timeout, md_err
    );

    modport slave (
        input  fd_instr, dx_instr, xm_instr, mw_instr, xm_err, mw_err, md_rdy, md_exc,
        output a_sel, b_sel, stall, md_start, md_busy, md_timeout, md_err
    );
endinterface

// File: rtl/pipeline_hazard_scoreboard.sv
// Bypass-select, load-use stall and mult/div sequencing for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add saturating stall-cycle counters (perf_lu_stalls, perf_md_stalls).
module pipeline_hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int ERR_REG    = 30,
    parameter int LINK_REG   = 31,
    parameter int MD_MAX_LAT = 40
) (
    input  logic clock,
    input  logic reset_n,
    pipeline_hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_md_stalls
`endif
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(MD_MAX_LAT);

    typedef logic [RW-1:0] reg_t;
    typedef struct packed {
        logic vld;
        reg_t idx;
    } reg_ref_t;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,  OP_BNE = 5'd2, OP_JAL = 5'd3, OP_JR   = 5'd4,  OP_ADDI = 5'd5,
        OP_BLT   = 5'd6,  OP_SW  = 5'd7, OP_LW  = 5'd8, OP_SETX = 5'd21, OP_BEX  = 5'd22
    } opcode_e;

    typedef enum logic { S_IDLE, S_BUSY } md_state_e;

    localparam reg_t           ERR_IDX   = reg_t'(ERR_REG);
    localparam reg_t           LINK_IDX  = reg_t'(LINK_REG);
    localparam logic [4:0]     ALUOP_MUL = 5'd6;
    localparam logic [4:0]     ALUOP_DIV = 5'd7;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(MD_MAX_LAT - 1);

    function automatic logic [4:0] f_op(input logic [XLEN-1:0] instr);
        return instr[XLEN-1 -: 5];
    endfunction
    function automatic reg_t f_rd(input logic [XLEN-1:0] instr);
        return instr[XLEN-6 -: RW];
    endfunction
    function automatic reg_t f_rs(input logic [XLEN-1:0] instr);
        return instr[XLEN-6-RW -: RW];
    endfunction
    function automatic reg_t f_rt(input logic [XLEN-1:0] instr);
        return instr[XLEN-6-2*RW -: RW];
    endfunction

    // A write to register 0 is discarded, so it never counts as a destination.
    function automatic reg_ref_t f_dest(input logic [XLEN-1:0] instr);
        reg_ref_t r;
        case (f_op(instr))
            OP_RTYPE, OP_ADDI, OP_LW: r.idx = f_rd(instr);
            OP_JAL:                   r.idx = LINK_IDX;
            OP_SETX:                  r.idx = ERR_IDX;
            default:                  r.idx = '0;
        endcase
        r.vld = (r.idx != '0);
        return r;
    endfunction

    function automatic reg_ref_t f_src_a(input logic [XLEN-1:0] instr);
        reg_ref_t r;
        r.vld = 1'b1;
        case (f_op(instr))
            OP_RTYPE, OP_ADDI, OP_SW, OP_LW: r.idx = f_rs(instr);
            OP_BNE, OP_BLT, OP_JR:           r.idx = f_rd(instr);
            OP_BEX:                          r.idx = ERR_IDX;
            default: begin
                r.vld = 1'b0;
                r.idx = '0;
            end
        endcase
        return r;
    endfunction

    function automatic reg_ref_t f_src_b(input logic [XLEN-1:0] instr);
        reg_ref_t r;
        r.vld = 1'b1;
        case (f_op(instr))
            OP_RTYPE:       r.idx = f_rt(instr);
            OP_BNE, OP_BLT: r.idx = f_rs(instr);
            OP_SW:          r.idx = f_rd(instr);
            default: begin
                r.vld = 1'b0;
                r.idx = '0;
            end
        endcase
        return r;
    endfunction

    // Status/exception value beats XM bypass, which beats MW writeback; a lw in XM has no data yet.
    function automatic logic [1:0] f_sel(input reg_ref_t src, input logic [XLEN-1:0] xm,
                                         input logic [XLEN-1:0] mw, input logic err);
        reg_ref_t xm_d = f_dest(xm);
        reg_ref_t mw_d = f_dest(mw);
        if (!src.vld)                                             return 2'd0;
        if (src.idx == ERR_IDX && err)                            return 2'd3;
        if (xm_d.vld && xm_d.idx == src.idx && f_op(xm) != OP_LW) return 2'd1;
        if (mw_d.vld && mw_d.idx == src.idx)                      return 2'd2;
        return 2'd0;
    endfunction

    md_state_e       r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            r_issued, w_issued_next;
    reg_ref_t        w_fd_a, w_fd_b;
    reg_t            w_dx_rd;
    logic            w_lu_stall, w_dx_md, w_stall;
    logic            w_md_start, w_md_stall, w_md_timeout, w_md_err;
    logic            w_unused_instr_bits;

    // Instruction bits the scoreboard never decodes (shamt, immediates, XM/MW sources).
    assign w_unused_instr_bits = ^{bus.fd_instr, bus.dx_instr, bus.xm_instr, bus.mw_instr};

    assign bus.a_sel = f_sel(f_src_a(bus.dx_instr), bus.xm_instr, bus.mw_instr, bus.xm_err | bus.mw_err);
    assign bus.b_sel = f_sel(f_src_b(bus.dx_instr), bus.xm_instr, bus.mw_instr, bus.xm_err | bus.mw_err);

    assign w_fd_a     = f_src_a(bus.fd_instr);
    assign w_fd_b     = f_src_b(bus.fd_instr);
    assign w_dx_rd    = f_rd(bus.dx_instr);
    assign w_lu_stall = (f_op(bus.dx_instr) == OP_LW) && (w_dx_rd != '0) &&
                        ((w_fd_a.vld && w_fd_a.idx == w_dx_rd) || (w_fd_b.vld && w_fd_b.idx == w_dx_rd));
    assign w_dx_md    = (f_op(bus.dx_instr) == OP_RTYPE) &&
                        (bus.dx_instr[6:2] == ALUOP_MUL || bus.dx_instr[6:2] == ALUOP_DIV);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_issued <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_issued <= w_issued_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_md_start   = 1'b0;
        w_md_stall   = 1'b0;
        w_md_timeout = 1'b0;
        w_md_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // reset_n gating keeps a DX mul from raising start/stall while reset is held.
                if (reset_n && w_dx_md && !r_issued) begin
                    w_md_start   = 1'b1;
                    w_md_stall   = 1'b1;
                    w_state_next = S_BUSY;
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                if (bus.md_rdy) begin
                    w_md_err     = bus.md_exc;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_md_timeout = 1'b1;
                    w_md_err     = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_md_stall = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_stall = w_lu_stall | w_md_stall;
        // DX advances on any unstalled edge, which retires the issued instruction.
        w_issued_next = w_md_start ? 1'b1 : (w_stall ? r_issued : 1'b0);
    end

    assign bus.stall      = w_stall;
    assign bus.md_start   = w_md_start;
    assign bus.md_busy    = (r_state == S_BUSY);
    assign bus.md_timeout = w_md_timeout;
    assign bus.md_err     = w_md_err;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_lu_stalls <= '0;
            perf_md_stalls <= '0;
        end else begin
            if (w_lu_stall && perf_lu_stalls != '1) perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (w_md_stall && perf_md_stalls != '1) perf_md_stalls <= perf_md_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized latch contents checked against
// a register-number level reference model of the bypass/stall rules.
module tb_pipeline_hazard_scoreboard;
    localparam int XLEN   = 32;
    localparam int MAXLAT = 40;
    localparam int ERR    = 30;
    localparam int LINK   = 31;
    localparam logic [31:0] NOP = 32'h0800_0000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    pipeline_hazard_scoreboard_if #(.XLEN(XLEN)) bus ();
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_stalls, perf_md_stalls;
`endif

    pipeline_hazard_scoreboard #(
        .XLEN(XLEN), .NREG(32), .ERR_REG(ERR), .LINK_REG(LINK), .MD_MAX_LAT(MAXLAT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
`ifdef HAZARD_PERF_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_md_stalls(perf_md_stalls)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int al);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(al), 2'b00};
    endfunction

    // Reference model: register numbers as ints, -1 meaning "none".
    function automatic int m_dest(input logic [31:0] i);
        int op = int'(i[31:27]);
        int d  = -1;
        if (op inside {0, 5, 8}) d = int'(i[26:22]);
        else if (op == 3)        d = LINK;
        else if (op == 21)       d = ERR;
        return (d == 0) ? -1 : d;
    endfunction

    function automatic int m_src(input logic [31:0] i, input bit opb);
        int op = int'(i[31:27]);
        if (!opb) begin
            if (op inside {0, 5, 7, 8}) return int'(i[21:17]);
            if (op inside {2, 6, 4})    return int'(i[26:22]);
            if (op == 22)               return ERR;
        end else begin
            if (op == 0)                return int'(i[16:12]);
            if (op inside {2, 6})       return int'(i[21:17]);
            if (op == 7)                return int'(i[26:22]);
        end
        return -1;
    endfunction

    function automatic logic [1:0] m_sel(input int src, input logic [31:0] xm, input logic [31:0] mw, input bit err);
        if (src < 0)                                          return 2'd0;
        if (src == ERR && err)                                return 2'd3;
        if (m_dest(xm) == src && int'(xm[31:27]) != 8)        return 2'd1;
        if (m_dest(mw) == src)                                return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_load_use(input logic [31:0] fd, input logic [31:0] dx);
        int rd = int'(dx[26:22]);
        return (int'(dx[31:27]) == 8) && (rd != 0) && (m_src(fd, 0) == rd || m_src(fd, 1) == rd);
    endfunction

    function automatic logic [31:0] rnd_instr(input bit allow_md);
        int ops[12] = '{0, 5, 7, 8, 2, 6, 4, 3, 21, 22, 1, 9};
        int regs[6] = '{0, 1, 2, 3, 30, 31};
        int al      = allow_md ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 5));
        return enc(ops[$urandom_range(0, 11)], regs[$urandom_range(0, 5)],
                   regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)], al);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_latches(input logic [31:0] fd, input logic [31:0] dx,
                               input logic [31:0] xm, input logic [31:0] mw);
        bus.fd_instr = fd;
        bus.dx_instr = dx;
        bus.xm_instr = xm;
        bus.mw_instr = mw;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        set_latches(NOP, enc(0, 8, 1, 2, 6), NOP, NOP);
        bus.xm_err = 1'b0; bus.mw_err = 1'b0; bus.md_rdy = 1'b1; bus.md_exc = 1'b1;
        #2;
        got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b0) begin bad++; $display("FAIL reset_hold: got %b expected 00000", got); end
        tick();
        got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b0) begin bad++; $display("FAIL reset_edge: got %b expected 00000", got); end
        set_latches(NOP, NOP, NOP, NOP);
        bus.md_rdy = 1'b0; bus.md_exc = 1'b0;
        reset_n = 1'b1;
        #1;
        got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b0 || {bus.a_sel, bus.b_sel} !== 4'b0) begin
            bad++; $display("FAIL reset_release: got %b sel %b expected 00000 sel 0000", got, {bus.a_sel, bus.b_sel});
        end
    endtask

    task automatic test_bypass();
        logic [31:0] add3 = enc(0, 3, 1, 2, 0);
        logic [31:0] sub4 = enc(0, 4, 3, 5, 1);
        logic [3:0]  exp_ab[4] = '{4'b0100, 4'b1000, 4'b0100, 4'b0001};
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: set_latches(NOP, sub4, add3, NOP);
                1: set_latches(NOP, sub4, NOP, add3);
                2: set_latches(NOP, sub4, add3, add3);
                default: set_latches(NOP, enc(0, 4, 5, 3, 1), add3, NOP);
            endcase
            #1;
            total++;
            if ({bus.a_sel, bus.b_sel} !== exp_ab[n]) begin
                bad++; $display("FAIL bypass_%0d: got a=%0d b=%0d expected %b", n, bus.a_sel, bus.b_sel, exp_ab[n]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] lw6   = enc(8, 6, 1, 0, 0);
        logic [31:0] addi7 = enc(5, 7, 6, 0, 0);
        int stalls = 0;
        set_latches(addi7, lw6, NOP, NOP);
        #1;
        if (bus.stall) stalls++;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b expected 1", bus.stall); end
        tick();
        set_latches(NOP, addi7, lw6, NOP);
        #1;
        if (bus.stall) stalls++;
        total++;
        if (bus.a_sel !== 2'd0) begin bad++; $display("FAIL lu_xm_sel: got %0d expected 0", bus.a_sel); end
        tick();
        set_latches(NOP, addi7, NOP, lw6);
        #1;
        if (bus.stall) stalls++;
        total++;
        if (bus.a_sel !== 2'd2) begin bad++; $display("FAIL lu_mw_sel: got %0d expected 2", bus.a_sel); end
        total++;
        if (stalls != 1) begin bad++; $display("FAIL lu_count: got %0d stall cycles expected 1", stalls); end
        set_latches(enc(5, 7, 0, 0, 0), enc(8, 0, 1, 0, 0), NOP, NOP);
        #1;
        total++;
        if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_r0: got %b expected 0", bus.stall); end
        set_latches(enc(7, 6, 2, 0, 0), lw6, NOP, NOP);
        #1;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_store_data: got %b expected 1", bus.stall); end
        tick();
        set_latches(NOP, NOP, NOP, NOP);
        tick();
    endtask

    task automatic test_err_status();
        logic [31:0] add9 = enc(0, 9, 30, 1, 0);
        logic [31:0] setx = enc(21, 0, 0, 5, 0);
        logic [31:0] bex  = enc(22, 0, 0, 0, 0);
        logic [1:0]  exp_a[6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        for (int n = 0; n < 6; n++) begin
            bus.xm_err = (n == 0 || n == 4);
            bus.mw_err = (n == 1);
            case (n)
                0, 1:    set_latches(NOP, add9, NOP, NOP);
                2, 4:    set_latches(NOP, bex, setx, NOP);
                3:       set_latches(NOP, bex, NOP, setx);
                default: set_latches(NOP, enc(4, 31, 0, 0, 0), enc(3, 0, 0, 0, 0), NOP);
            endcase
            #1;
            total++;
            if (bus.a_sel !== exp_a[n] || bus.b_sel !== 2'd0) begin
                bad++; $display("FAIL err_status_%0d: got a=%0d b=%0d expected a=%0d b=0", n, bus.a_sel, bus.b_sel, exp_a[n]);
            end
        end
        bus.xm_err = 1'b0; bus.mw_err = 1'b0;
        set_latches(NOP, NOP, NOP, NOP);
    endtask

    task automatic test_random();
        logic [31:0] fd, dx, xm, mw;
        bit          xe, me;
        logic [1:0]  ea, eb;
        bit          es;
        for (int n = 0; n < 300; n++) begin
            fd = rnd_instr(1); dx = rnd_instr(0); xm = rnd_instr(1); mw = rnd_instr(1);
            xe = ($urandom_range(0, 3) == 0);
            me = ($urandom_range(0, 3) == 0);
            set_latches(fd, dx, xm, mw);
            bus.xm_err = xe; bus.mw_err = me;
            #1;
            ea = m_sel(m_src(dx, 0), xm, mw, xe | me);
            eb = m_sel(m_src(dx, 1), xm, mw, xe | me);
            es = m_load_use(fd, dx);
            total++;
            if (bus.a_sel !== ea) begin bad++; $display("FAIL rand_a[%0d]: got %0d expected %0d dx=%h xm=%h mw=%h", n, bus.a_sel, ea, dx, xm, mw); end
            total++;
            if (bus.b_sel !== eb) begin bad++; $display("FAIL rand_b[%0d]: got %0d expected %0d dx=%h xm=%h mw=%h", n, bus.b_sel, eb, dx, xm, mw); end
            total++;
            if (bus.stall !== es || bus.md_start !== 1'b0) begin
                bad++; $display("FAIL rand_stall[%0d]: got stall=%b start=%b expected %b/0 fd=%h dx=%h", n, bus.stall, bus.md_start, es, fd, dx);
            end
            tick();
        end
        bus.xm_err = 1'b0; bus.mw_err = 1'b0;
        set_latches(NOP, NOP, NOP, NOP);
        tick();
    endtask

    // One mult/div op: cycle k=0 is the start cycle, k>=1 are BUSY cycles; rdy_at<1 means never.
    task automatic run_md(input string name, input logic [31:0] instr, input int rdy_at,
                          input bit exc, input logic [31:0] next_dx);
        int         last = (rdy_at >= 1 && rdy_at <= MAXLAT) ? rdy_at : MAXLAT;
        int         starts = 0;
        int         stalls = 0;
        bit         rdy_now, exc_now, rel_rdy, rel_to;
        logic [4:0] got, exp;
        bus.dx_instr = instr;
        for (int k = 0; k <= last; k++) begin
            rdy_now = (k == rdy_at);
            exc_now = rdy_now ? exc : bit'($urandom_range(0, 1));
            bus.md_rdy = rdy_now;
            bus.md_exc = exc_now;
            #1;
            rel_rdy = rdy_now && (k >= 1);
            rel_to  = (k == MAXLAT) && !rel_rdy;
            exp = {k == 0, k >= 1, !(rel_rdy || rel_to), rel_to, rel_rdy ? exc_now : rel_to};
            got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
            total++;
            if (got !== exp) begin bad++; $display("FAIL %s cycle %0d: got %b expected %b", name, k, got, exp); end
            if (bus.md_start) starts++;
            if (bus.stall) stalls++;
            tick();
        end
        total++;
        if (starts != 1 || stalls != last) begin
            bad++; $display("FAIL %s totals: got starts=%0d stalls=%0d expected 1/%0d", name, starts, stalls, last);
        end
        bus.dx_instr = next_dx;
        bus.md_rdy = 1'b0; bus.md_exc = 1'b0;
        #1;
        got = {1'b0, bus.md_busy, 1'b0, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b0) begin bad++; $display("FAIL %s after: got %b expected 00000", name, got); end
    endtask

    task automatic test_md_ready();
        run_md("mul_rdy17_exc", enc(0, 8, 1, 2, 6), 17, 1'b1, NOP);
        run_md("div_rdy17", enc(0, 8, 1, 2, 7), 17, 1'b0, NOP);
    endtask

    task automatic test_md_timeout();
        run_md("md_timeout", enc(0, 9, 3, 4, 7), -1, 1'b0, NOP);
        run_md("rdy_at_limit", enc(0, 9, 3, 4, 6), MAXLAT, 1'b0, NOP);
    endtask

    task automatic test_back_to_back();
        run_md("b2b_first", enc(0, 8, 1, 2, 6), 1, 1'b1, enc(0, 9, 2, 3, 7));
        run_md("b2b_second", enc(0, 9, 2, 3, 7), 1, 1'b0, NOP);
    endtask

    task automatic test_md_idle_rdy();
        logic [4:0] got;
        bus.md_rdy = 1'b1; bus.md_exc = 1'b1;
        for (int n = 0; n < 2; n++) begin
            #1;
            got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
            total++;
            if (got !== 5'b0) begin bad++; $display("FAIL idle_rdy_%0d: got %b expected 00000", n, got); end
            tick();
        end
        bus.md_rdy = 1'b0; bus.md_exc = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [4:0] got;
        set_latches(NOP, enc(0, 8, 1, 2, 6), NOP, NOP);
        bus.md_rdy = 1'b0; bus.md_exc = 1'b0;
        tick();
        for (int k = 1; k < 5; k++) tick();
        total++;
        if ({bus.md_busy, bus.stall} !== 2'b11) begin bad++; $display("FAIL rmb_busy5: got %b expected 11", {bus.md_busy, bus.stall}); end
        reset_n = 1'b0;
        #1;
        got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b0) begin bad++; $display("FAIL rmb_async: got %b expected 00000", got); end
        tick();
        reset_n = 1'b1;
        #1;
        got = {bus.md_start, bus.md_busy, bus.stall, bus.md_timeout, bus.md_err};
        total++;
        if (got !== 5'b10100) begin bad++; $display("FAIL rmb_restart: got %b expected 10100", got); end
        tick();
        bus.md_rdy = 1'b1;
        #1;
        total++;
        if ({bus.md_busy, bus.stall, bus.md_err} !== 3'b100) begin
            bad++; $display("FAIL rmb_release: got %b expected 100", {bus.md_busy, bus.stall, bus.md_err});
        end
        tick();
        bus.md_rdy = 1'b0;
        bus.dx_instr = NOP;
        #1;
        total++;
        if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL rmb_idle: got %b expected 0", bus.md_busy); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_err_status();
        test_random();
        test_md_ready();
        test_md_timeout();
        test_back_to_back();
        test_md_idle_rdy();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
